fpadd_task2: RTL and testbench

- IEEE-754 single-precision adder: computes s = a + b with round-to-nearest-even.
- Handles zero, infinity, NaN and signed-operand cases.
- Combinational datapath with a single output register stage.
- Sits in the Task2 arithmetic path as a standalone FP add unit.

---
 rtl/fpadd_pkg.sv | 32 +++
 rtl/fpadd_lzc.sv | 16 +
 rtl/fpadd_task2.sv | 132 +++++++++++++
 tb/tb_fpadd_task2.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/fpadd_pkg.sv
// rtl/fpadd_pkg.sv - binary32 constants, field struct and operand classifier for the FP adder
package fpadd_pkg;

    localparam int          EXP_W   = 8;
    localparam int          FRAC_W  = 23;
    localparam int          BIAS    = 127;
    localparam logic [31:0] QNAN    = 32'h7FC00000;
    localparam logic [31:0] POS_INF = 32'h7F800000;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } fp32_t;

    typedef enum logic [2:0] {
        FP_ZERO,
        FP_SUBN,
        FP_NORM,
        FP_INF,
        FP_NAN
    } fp_class_e;

    function automatic fp_class_e fp_classify(input fp32_t x);
        if (x.exp == '1)
            return (x.frac != '0) ? FP_NAN : FP_INF;
        if (x.exp == '0)
            return (x.frac != '0) ? FP_SUBN : FP_ZERO;
        return FP_NORM;
    endfunction

endpackage

// File: rtl/fpadd_lzc.sv
// rtl/fpadd_lzc.sv - 27-bit leading-zero counter for post-subtraction normalization
module fpadd_lzc (
    input  logic [26:0] i_data,
    output logic [4:0]  o_count
);

    // Scanning upward lets the highest set bit win; all-zero input reports 27.
    always_comb begin
        o_count = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (i_data[i])
                o_count = 5'(26 - i);
        end
    end

endmodule

// File: rtl/fpadd_task2.sv
// rtl/fpadd_task2.sv - binary32 RNE adder, one register stage; FPADD_DENORM_EN enables gradual underflow
module fpadd_task2
    import fpadd_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    output logic [31:0] s
);

    fp32_t       w_a, w_b;
    fp_class_e   w_ca, w_cb;
    logic [7:0]  w_ea, w_eb, w_xe, w_ye, w_diff;
    logic [23:0] w_ma, w_mb, w_xm, w_ym;
    logic        w_swap, w_xs, w_sub, w_tiny, w_uflow_flush, w_rnd;
    logic [4:0]  w_shamt, w_lz;
    logic [26:0] w_yx, w_ysh, w_ylost, w_yal, w_norm;
    logic [27:0] w_sum;
    logic [9:0]  w_e, w_e2;
    logic [24:0] w_mr;
    logic [23:0] w_mant;
    logic [31:0] w_res;
    logic [31:0] r_s;
    logic        r_valid;

`ifdef FPADD_DENORM_EN
    assign w_a           = a;
    assign w_b           = b;
    assign w_uflow_flush = 1'b0;
`else
    assign w_a           = (a[30:23] == 8'd0) ? {a[31], 31'd0} : a;
    assign w_b           = (b[30:23] == 8'd0) ? {b[31], 31'd0} : b;
    assign w_uflow_flush = w_tiny;
`endif

    assign w_ca = fp_classify(w_a);
    assign w_cb = fp_classify(w_b);

    // Subnormals enter the datapath as exponent 1 without the hidden bit.
    assign w_ea = (w_a.exp == 8'd0) ? 8'd1 : w_a.exp;
    assign w_eb = (w_b.exp == 8'd0) ? 8'd1 : w_b.exp;
    assign w_ma = {(w_a.exp != 8'd0), w_a.frac};
    assign w_mb = {(w_b.exp != 8'd0), w_b.frac};

    assign w_swap = {w_eb, w_mb} > {w_ea, w_ma};
    assign w_xe   = w_swap ? w_eb : w_ea;
    assign w_xm   = w_swap ? w_mb : w_ma;
    assign w_xs   = w_swap ? w_b.sign : w_a.sign;
    assign w_ye   = w_swap ? w_ea : w_eb;
    assign w_ym   = w_swap ? w_ma : w_mb;
    assign w_sub  = w_a.sign ^ w_b.sign;

    assign w_diff  = w_xe - w_ye;
    assign w_shamt = (w_diff > 8'd26) ? 5'd26 : w_diff[4:0];
    assign w_yx    = {w_ym, 3'b000};
    assign w_ysh   = w_yx >> w_shamt;
    assign w_ylost = w_yx & ~({27{1'b1}} << w_shamt);
    assign w_yal   = {w_ysh[26:1], w_ysh[0] | (|w_ylost)};

    assign w_sum = w_sub ? ({1'b0, w_xm, 3'b000} - {1'b0, w_yal})
                         : ({1'b0, w_xm, 3'b000} + {1'b0, w_yal});

    fpadd_lzc u_lzc (
        .i_data  (w_sum[26:0]),
        .o_count (w_lz)
    );

    // Full normalization would drop the exponent below 1: pin it at 1 instead.
    assign w_tiny = !w_sum[27] && ({2'b00, w_xe} <= {5'd0, w_lz});

    always_comb begin
        w_norm = '0;
        w_e    = 10'd1;
        if (w_sum[27]) begin
            w_norm = {w_sum[27:2], w_sum[1] | w_sum[0]};
            w_e    = {2'b00, w_xe} + 10'd1;
        end else if (!w_tiny) begin
            w_norm = w_sum[26:0] << w_lz;
            w_e    = {2'b00, w_xe} - {5'd0, w_lz};
        end else begin
            w_norm = w_sum[26:0] << (w_xe - 8'd1);
            w_e    = 10'd1;
        end
    end

    assign w_rnd  = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
    assign w_mr   = {1'b0, w_norm[26:3]} + {24'd0, w_rnd};
    assign w_mant = w_mr[24] ? w_mr[24:1] : w_mr[23:0];
    assign w_e2   = w_e + {9'd0, w_mr[24]};

    always_comb begin
        w_res = {w_xs, (w_mant[23] ? w_e2[7:0] : 8'd0), w_mant[22:0]};
        if (w_ca == FP_NAN || w_cb == FP_NAN)
            w_res = QNAN;
        else if (w_ca == FP_INF && w_cb == FP_INF && w_sub)
            w_res = QNAN;
        else if (w_ca == FP_INF)
            w_res = w_a;
        else if (w_cb == FP_INF)
            w_res = w_b;
        else if (w_ca == FP_ZERO && w_cb == FP_ZERO)
            w_res = {w_a.sign & w_b.sign, 31'd0};
        else if (w_ca == FP_ZERO)
            w_res = w_b;
        else if (w_cb == FP_ZERO)
            w_res = w_a;
        else if (w_sum == 28'd0)
            w_res = 32'd0;
        else if (w_e2 >= 10'd255)
            w_res = {w_xs, POS_INF[30:0]};
        else if (w_uflow_flush)
            w_res = {w_xs, 31'd0};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s     <= 32'd0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= in_valid;
            if (in_valid)
                r_s <= w_res;
        end
    end

    assign s         = r_s;
    assign out_valid = r_valid;

endmodule

// File: tb/tb_fpadd_task2.sv
// tb/tb_fpadd_task2.sv - scoreboard bench for fpadd_task2
module tb_fpadd_task2;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] a, b;
    logic        out_valid;
    logic [31:0] s;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    fpadd_task2 dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .s         (s)
    );

    task automatic apply(input logic [31:0] ta, input logic [31:0] tb_v, input logic [31:0] te);
        a        = ta;
        b        = tb_v;
        in_valid = 1'b1;
        exp_q.push_back(te);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        a        = 32'hDEADBEEF;
        b        = 32'h12345678;
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        in_valid = 1'b1;
        a        = 32'h3FC00000;
        b        = 32'h40500000;
        repeat (2) @(negedge clk);
        n_checks++;
        if (s !== 32'd0) $display("FAIL reset_s: got %h want 00000000", s);
        else n_pass++;
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", out_valid);
        else n_pass++;
        reset = 1'b0;
        idle(1);
    endtask

    task automatic test_normal();
        logic [31:0] v[0:2][0:2];
        logic [31:0] e;
        v = '{'{32'h3FC00000, 32'h40500000, 32'h40980000},
              '{32'h3F800000, 32'h3F800000, 32'h40000000},
              '{32'h40000000, 32'hBF000000, 32'h3FC00000}};
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL normal_pre_valid: got %b want 0", out_valid);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            apply(v[i][0], v[i][1], v[i][2]);
            e = exp_q.pop_front();
            n_checks++;
            if (out_valid !== 1'b1 || s !== e)
                $display("FAIL normal[%0d]: got s=%h v=%b want s=%h v=1", i, s, out_valid, e);
            else n_pass++;
        end
        idle(1);
    endtask

    task automatic test_special();
        logic [31:0] v[0:8][0:2];
        logic [31:0] e, denorm_exp;
`ifdef FPADD_DENORM_EN
        denorm_exp = 32'h00000005;
`else
        denorm_exp = 32'h00000000;
`endif
        v = '{'{32'h00000005, 32'h00000000, denorm_exp},
              '{32'h7F800580, 32'h00000014, 32'h7FC00000},
              '{32'h7F800000, 32'h00000014, 32'h7F800000},
              '{32'h00000000, 32'h00000000, 32'h00000000},
              '{32'h80000000, 32'h80000000, 32'h80000000},
              '{32'h40000000, 32'hC0000000, 32'h00000000},
              '{32'hFF800000, 32'h7F800000, 32'h7FC00000},
              '{32'h7F800000, 32'h7F800000, 32'h7F800000},
              '{32'h00000000, 32'hBF800000, 32'hBF800000}};
        for (int i = 0; i < 9; i++) begin
            apply(v[i][0], v[i][1], v[i][2]);
            e = exp_q.pop_front();
            n_checks++;
            if (out_valid !== 1'b1 || s !== e)
                $display("FAIL special[%0d]: got s=%h v=%b want s=%h v=1", i, s, out_valid, e);
            else n_pass++;
        end
        idle(1);
    endtask

    task automatic test_mixed_signs();
        logic [31:0] v[0:2][0:2];
        logic [31:0] e;
        v = '{'{32'h40080000, 32'hC000C000, 32'h3DE80000},
              '{32'hC0080000, 32'h4000C000, 32'hBDE80000},
              '{32'hC0080000, 32'hC000C000, 32'hC0846000}};
        for (int i = 0; i < 3; i++) begin
            apply(v[i][0], v[i][1], v[i][2]);
            e = exp_q.pop_front();
            n_checks++;
            if (out_valid !== 1'b1 || s !== e)
                $display("FAIL mixed[%0d]: got s=%h v=%b want s=%h v=1", i, s, out_valid, e);
            else n_pass++;
        end
        idle(1);
    endtask

    task automatic test_rounding();
        logic [31:0] v[0:3][0:2];
        logic [31:0] e;
        v = '{'{32'h3F800000, 32'h33800000, 32'h3F800000},
              '{32'h3F800001, 32'h33800000, 32'h3F800002},
              '{32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000},
              '{32'hFF7FFFFF, 32'hFF7FFFFF, 32'hFF800000}};
        for (int i = 0; i < 4; i++) begin
            apply(v[i][0], v[i][1], v[i][2]);
            e = exp_q.pop_front();
            n_checks++;
            if (out_valid !== 1'b1 || s !== e)
                $display("FAIL round[%0d]: got s=%h v=%b want s=%h v=1", i, s, out_valid, e);
            else n_pass++;
        end
        idle(1);
    endtask

    task automatic test_back_to_back_and_hold();
        logic [31:0] v[0:3][0:2];
        logic [31:0] e, last;
        v = '{'{32'h3F800000, 32'h40000000, 32'h40400000},
              '{32'h40000000, 32'h40000000, 32'h40800000},
              '{32'h40400000, 32'h3F800000, 32'h40800000},
              '{32'h40800000, 32'h40800000, 32'h41000000}};
        last = 32'h0;
        for (int i = 0; i < 4; i++) begin
            apply(v[i][0], v[i][1], v[i][2]);
            e = exp_q.pop_front();
            last = e;
            n_checks++;
            if (out_valid !== 1'b1 || s !== e)
                $display("FAIL b2b[%0d]: got s=%h v=%b want s=%h v=1", i, s, out_valid, e);
            else n_pass++;
        end
        for (int i = 0; i < 3; i++) begin
            idle(1);
            n_checks++;
            if (out_valid !== 1'b0 || s !== last)
                $display("FAIL hold[%0d]: got s=%h v=%b want s=%h v=0", i, s, out_valid, last);
            else n_pass++;
        end
    endtask

    task automatic test_reset_midstream();
        logic [31:0] e;
        apply(32'h3FC00000, 32'h40500000, 32'h40980000);
        e = exp_q.pop_front();
        n_checks++;
        if (out_valid !== 1'b1 || s !== e)
            $display("FAIL midrst_pre: got s=%h v=%b want s=%h v=1", s, out_valid, e);
        else n_pass++;
        a        = 32'h40080000;
        b        = 32'hC000C000;
        in_valid = 1'b1;
        reset    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || s !== 32'd0)
            $display("FAIL midrst: got s=%h v=%b want s=00000000 v=0", s, out_valid);
        else n_pass++;
        apply(32'h40080000, 32'hC000C000, 32'h3DE80000);
        e = exp_q.pop_front();
        n_checks++;
        if (out_valid !== 1'b1 || s !== e)
            $display("FAIL midrst_post: got s=%h v=%b want s=%h v=1", s, out_valid, e);
        else n_pass++;
        idle(1);
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        a        = 32'd0;
        b        = 32'd0;
        @(negedge clk);
        test_reset();
        test_normal();
        test_special();
        test_mixed_signs();
        test_rounding();
        test_back_to_back_and_hold();
        test_reset_midstream();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
